// File: rtl/syn_fifo_ext.sv
// rtl/syn_fifo_ext.sv - single-clock FIFO with thresholds, occupancy count, error pulses and optional FWFT read
module syn_fifo_ext #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic                     read,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // A write into a full FIFO is still taken when a read frees a slot on the same edge.
  assign rd_ok = read && !empty;
  assign wr_ok = write && (!full || rd_ok);

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= write && !wr_ok;
      underflow <= read && !rd_ok;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; read only acknowledges it.
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (reset) begin
          data_out <= '0;
        end else if (rd_ok) begin
          data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo_ext.sv
// tb/tb_syn_fifo_ext.sv - self-checking bench for syn_fifo_ext, standard and FWFT builds side by side
module tb_syn_fifo_ext;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int AE_LEVEL = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] data_in;

  logic [WIDTH-1:0] dout_s, dout_f;
  logic             full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic             full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [CW-1:0]    count_s, count_f;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_dout;
  bit               m_ovf;
  bit               m_unf;

  always #5 clk = ~clk;

  syn_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .write(write), .read(read), .data_in(data_in),
    .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
  );

  syn_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .write(write), .read(read), .data_in(data_in),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_std",  int'(count_s), n);
    chk("count_fwft", int'(count_f), n);
    chk("empty_std",  int'(empty_s), int'(n == 0));
    chk("empty_fwft", int'(empty_f), int'(n == 0));
    chk("full_std",   int'(full_s),  int'(n == DEPTH));
    chk("full_fwft",  int'(full_f),  int'(n == DEPTH));
    chk("af_std",     int'(af_s),    int'(n >= AF_LEVEL));
    chk("af_fwft",    int'(af_f),    int'(n >= AF_LEVEL));
    chk("ae_std",     int'(ae_s),    int'(n <= AE_LEVEL));
    chk("ae_fwft",    int'(ae_f),    int'(n <= AE_LEVEL));
    chk("ovf_std",    int'(ovf_s),   int'(m_ovf));
    chk("ovf_fwft",   int'(ovf_f),   int'(m_ovf));
    chk("unf_std",    int'(unf_s),   int'(m_unf));
    chk("unf_fwft",   int'(unf_f),   int'(m_unf));
    chk("dout_std",   int'(dout_s),  int'(m_dout));
    if (n > 0) chk("dout_fwft", int'(dout_f), int'(q[0]));
  endtask

  // One clock: apply inputs, advance the queue model, compare just after the edge.
  task automatic step(input bit rst, input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit rd, wr;
    reset = rst; write = w; read = r; data_in = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd = r && (q.size() > 0);
      wr = w && ((q.size() < DEPTH) || rd);
      m_unf = r && !rd;
      m_ovf = w && !wr;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  typedef struct {
    bit               rst;
    bit               w;
    bit               r;
    logic [WIDTH-1:0] d;
    int               e_count;
    bit               e_empty;
    logic [WIDTH-1:0] e_dout;
  } vec_t;

  vec_t             vecs [9];
  logic [WIDTH-1:0] sent [$];
  logic [WIDTH-1:0] v;

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = '0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    vecs[0] = '{1, 0, 0, 8'h00, 0, 1, 8'h00};
    vecs[1] = '{0, 1, 0, 8'hA1, 1, 0, 8'h00};
    vecs[2] = '{0, 1, 0, 8'hB2, 2, 0, 8'h00};
    vecs[3] = '{0, 1, 0, 8'hC3, 3, 0, 8'h00};
    vecs[4] = '{0, 1, 0, 8'hD4, 4, 0, 8'h00};
    vecs[5] = '{0, 0, 1, 8'h00, 3, 0, 8'hA1};
    vecs[6] = '{0, 0, 1, 8'h00, 2, 0, 8'hB2};
    vecs[7] = '{0, 0, 0, 8'h00, 2, 0, 8'hB2};
    vecs[8] = '{0, 1, 1, 8'hE5, 2, 0, 8'hC3};

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
      chk("vec_count", int'(count_s), vecs[i].e_count);
      chk("vec_empty", int'(empty_s), int'(vecs[i].e_empty));
      chk("vec_dout",  int'(dout_s),  int'(vecs[i].e_dout));
    end

    // Fill to full, then overflow (two back-to-back rejections)
    step(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, WIDTH'($urandom));
    chk("fill_full", int'(full_s), 1);
    chk("fill_af",   int'(af_s), 1);
    step(0, 1, 0, 8'hEE);
    chk("ovf_pulse", int'(ovf_s), 1);
    chk("ovf_count", int'(count_s), DEPTH);
    step(0, 1, 0, 8'hEF);
    chk("ovf_hold", int'(ovf_s), 1);
    step(0, 0, 0, 0);
    chk("ovf_clear", int'(ovf_s), 0);

    // Full: simultaneous read/write, 5A surfaces as 16th read
    step(0, 1, 1, 8'h5A);
    chk("fullrw_count", int'(count_s), DEPTH);
    chk("fullrw_ovf", int'(ovf_s), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    chk("5a_out", int'(dout_s), 8'h5A);
    chk("drain_empty", int'(empty_s), 1);
    step(0, 0, 1, 0);
    chk("unf_pulse", int'(unf_s), 1);

    // Empty: simultaneous read/write
    step(0, 1, 1, 8'h3C);
    chk("emptyrw_unf", int'(unf_s), 1);
    chk("emptyrw_count", int'(count_s), 1);
    chk("fwft_3c", int'(dout_f), 8'h3C);

    // Pointer wrap at constant occupancy 3
    step(1, 0, 0, 0);
    sent.delete();
    for (int i = 0; i < 3; i++) begin
      v = WIDTH'($urandom);
      sent.push_back(v);
      step(0, 1, 0, v);
    end
    for (int k = 0; k < 40; k++) begin
      v = WIDTH'($urandom);
      sent.push_back(v);
      step(0, 1, 1, v);
      chk("wrap_dout", int'(dout_s), int'(sent[k]));
      chk("wrap_count", int'(count_s), 3);
    end

    // Reset mid-stream with a write on the same edge
    for (int i = 0; i < 6; i++) step(0, 1, 0, WIDTH'($urandom));
    chk("pre_reset_count", int'(count_s), 9);
    step(1, 1, 0, 8'h77);
    chk("rst_count", int'(count_s), 0);
    chk("rst_empty", int'(empty_s), 1);
    chk("rst_ae", int'(ae_s), 1);
    chk("rst_dout", int'(dout_s), 0);
    step(0, 0, 1, 0);
    chk("rst_nostore", int'(unf_s), 1);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50, WIDTH'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
